// File: rtl/piso_shift_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the piso_shift_ctrl serialiser.
//   state_e    : FSM state encoding (IDLE / SHIFT / PARITY, 2 bits)
//   WIDTH_MIN  : smallest legal data word width
//   WIDTH_MAX  : largest legal data word width
//   cnt_bits() : width of the bit counter able to hold WIDTH
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  // The counter must represent the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_ctrl_if.sv
// ---------------------------------------------------------------------------
// piso_shift_ctrl_if
// Load handshake and serial-side signals of the serialiser.
//   load_valid / load_ready / load_data : parallel word handshake
//   sin        : fill bit shifted into the vacated register end
//   shift_en   : consumer takes the current sout bit
//   sout / sout_valid : serial bit and its qualifier
//   busy       : a word is in flight
//   done       : one-cycle pulse after the final bit is consumed
// Modports: master (producer/consumer side), slave (the serialiser).
// ---------------------------------------------------------------------------
interface piso_shift_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             sin;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, sin, shift_en,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, sin, shift_en,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_shift_ctrl_bit_cnt.sv
// ---------------------------------------------------------------------------
// piso_bit_cnt
// Loadable down-counter tracking the data bits still to be emitted.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset (counter -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one
//   cnt      : current count
//   last     : cnt == 1
// ---------------------------------------------------------------------------
module piso_bit_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/piso_shift_ctrl.sv
// ---------------------------------------------------------------------------
// piso_shift_ctrl
// Parallel-in/serial-out shifter with valid/ready load, stall (shift_en),
// bit counter and completion pulse.
//   WIDTH     : data word width, 2..64
//   MSB_FIRST : 1 = emit bit WIDTH-1 first, 0 = emit bit 0 first
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : piso_shift_ctrl_if slave modport (handshake + serial side)
// Optional feature macro: PISO_SHIFT_CTRL_PARITY_EN
//   When defined, an even-parity bit is emitted after the last data bit.
// ---------------------------------------------------------------------------
module piso_shift_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_shift_ctrl_if.slave  bus
);

  localparam int            CW       = cnt_bits(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("piso_shift_ctrl: WIDTH out of range 2..64");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec;
  logic [CW-1:0]    cnt_val;
  logic             cnt_last;
  logic [WIDTH-1:0] sreg_shifted;
  logic             sreg_head;

`ifdef PISO_SHIFT_CTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  // Direction-dependent shift path and output tap.
  if (MSB_FIRST) begin : g_msb
    assign sreg_shifted = {sreg_q[WIDTH-2:0], bus.sin};
    assign sreg_head    = sreg_q[WIDTH-1];
  end else begin : g_lsb
    assign sreg_shifted = {bus.sin, sreg_q[WIDTH-1:1]};
    assign sreg_head    = sreg_q[0];
  end

  piso_bit_cnt #(.CW(CW)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A load wins over any shift_en seen in the same cycle.
        if (bus.load_valid) begin
          sreg_d   = bus.load_data;
          cnt_load = 1'b1;
          state_d  = ST_SHIFT;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
          par_d    = ^bus.load_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (bus.shift_en) begin
          sreg_d  = sreg_shifted;
          // Guard keeps the counter from wrapping even if state were corrupted.
          cnt_dec = (cnt_val != '0);
          if (cnt_last) begin
`ifdef PISO_SHIFT_CTRL_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      ST_PARITY: begin
        if (bus.shift_en) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
    end
  end

`ifdef PISO_SHIFT_CTRL_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  logic in_shift, in_parity;
  assign in_shift  = (state_q == ST_SHIFT);
  assign in_parity = (state_q == ST_PARITY);

  assign bus.load_ready = (state_q == ST_IDLE);
  assign bus.busy       = in_shift | in_parity;
  assign bus.sout_valid = in_shift | in_parity;
  assign bus.done       = done_q;

`ifdef PISO_SHIFT_CTRL_PARITY_EN
  assign bus.sout = (in_shift & sreg_head) | (in_parity & par_q);
`else
  assign bus.sout = in_shift & sreg_head;
`endif

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_ctrl
// Drives three serialisers (8-bit MSB-first, 8-bit LSB-first, 5-bit
// MSB-first) from shared stimulus and compares every output, every cycle,
// against a per-instance list-of-pending-bits reference model.
// Honours PISO_SHIFT_CTRL_PARITY_EN for the expected parity bit.
// ---------------------------------------------------------------------------
module tb_piso_shift_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [63:0] load_data;
  logic        sin;
  logic        shift_en;

  always #5 clk = ~clk;

  piso_shift_ctrl_if #(.WIDTH(8)) if_m8 ();
  piso_shift_ctrl_if #(.WIDTH(8)) if_l8 ();
  piso_shift_ctrl_if #(.WIDTH(5)) if_m5 ();

  assign if_m8.load_valid = load_valid;
  assign if_m8.load_data  = load_data[7:0];
  assign if_m8.sin        = sin;
  assign if_m8.shift_en   = shift_en;
  assign if_l8.load_valid = load_valid;
  assign if_l8.load_data  = load_data[7:0];
  assign if_l8.sin        = sin;
  assign if_l8.shift_en   = shift_en;
  assign if_m5.load_valid = load_valid;
  assign if_m5.load_data  = load_data[4:0];
  assign if_m5.sin        = sin;
  assign if_m5.shift_en   = shift_en;

  piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m8 (
    .clk(clk), .rst_n(rst_n), .bus(if_m8.slave));
  piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l8 (
    .clk(clk), .rst_n(rst_n), .bus(if_l8.slave));
  piso_shift_ctrl #(.WIDTH(5), .MSB_FIRST(1'b1)) dut_m5 (
    .clk(clk), .rst_n(rst_n), .bus(if_m5.slave));

  logic obs_ready [NI];
  logic obs_busy  [NI];
  logic obs_valid [NI];
  logic obs_sout  [NI];
  logic obs_done  [NI];

  assign obs_ready[0] = if_m8.load_ready;
  assign obs_busy[0]  = if_m8.busy;
  assign obs_valid[0] = if_m8.sout_valid;
  assign obs_sout[0]  = if_m8.sout;
  assign obs_done[0]  = if_m8.done;
  assign obs_ready[1] = if_l8.load_ready;
  assign obs_busy[1]  = if_l8.busy;
  assign obs_valid[1] = if_l8.sout_valid;
  assign obs_sout[1]  = if_l8.sout;
  assign obs_done[1]  = if_l8.done;
  assign obs_ready[2] = if_m5.load_ready;
  assign obs_busy[2]  = if_m5.busy;
  assign obs_valid[2] = if_m5.sout_valid;
  assign obs_sout[2]  = if_m5.sout;
  assign obs_done[2]  = if_m5.done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the ordered list of bits the instance still owes.
  logic exp_bits [NI][72];
  int   exp_len  [NI];
  int   exp_pos  [NI];
  logic exp_done [NI];
  int   words_done [NI];

  function automatic int inst_w(input int i);
    return (i == 2) ? 5 : 8;
  endfunction

  function automatic bit inst_msb(input int i);
    return (i != 1);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      logic busy_e;
      logic sout_e;
      busy_e = (exp_pos[i] < exp_len[i]);
      sout_e = busy_e ? exp_bits[i][exp_pos[i]] : 1'b0;
      check_eq($sformatf("ready%0d", i), 64'(obs_ready[i]), 64'(!busy_e));
      check_eq($sformatf("busy%0d", i),  64'(obs_busy[i]),  64'(busy_e));
      check_eq($sformatf("valid%0d", i), 64'(obs_valid[i]), 64'(busy_e));
      check_eq($sformatf("sout%0d", i),  64'(obs_sout[i]),  64'(sout_e));
      check_eq($sformatf("done%0d", i),  64'(obs_done[i]),  64'(exp_done[i]));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        exp_len[i]  = 0;
        exp_pos[i]  = 0;
        exp_done[i] = 1'b0;
      end else begin
        exp_done[i] = 1'b0;
        if (exp_pos[i] >= exp_len[i]) begin
          if (load_valid) begin
            int          w;
            logic [63:0] mask;
            logic [63:0] word;
            w    = inst_w(i);
            mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
            word = load_data & mask;
            for (int k = 0; k < w; k++)
              exp_bits[i][k] = inst_msb(i) ? word[w-1-k] : word[k];
            exp_len[i] = w;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
            exp_bits[i][w] = ^word;
            exp_len[i]     = w + 1;
`endif
            exp_pos[i] = 0;
            $display("[TB] inst%0d accept word=%0h", i, word);
          end
        end else if (shift_en) begin
          exp_pos[i]++;
          if (exp_pos[i] == exp_len[i]) begin
            exp_done[i] = 1'b1;
            words_done[i]++;
          end
        end
      end
    end
  endtask

  // One clock: check what the last edge produced, then present new inputs
  // and advance the model to what the coming edge must produce.
  task automatic cycle(input logic rn, input logic lv, input logic [63:0] ld, input logic se);
    @(negedge clk);
    check_outputs();
    rst_n      = rn;
    load_valid = lv;
    load_data  = ld;
    shift_en   = se;
    sin        = 1'($urandom);
    model_step();
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    shift_en   = 1'b0;
    sin        = 1'b0;
    for (int i = 0; i < NI; i++) begin
      exp_len[i]    = 0;
      exp_pos[i]    = 0;
      exp_done[i]   = 1'b0;
      words_done[i] = 0;
    end
    repeat (2) @(posedge clk);

    // Reset held, then idle with noise on shift_en.
    cycle(1'b0, 1'b0, 64'h0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 64'h0, 1'b1);

    // 0xA5 with shift_en held high.
    cycle(1'b1, 1'b1, 64'hA5, 1'b1);
    repeat (12) cycle(1'b1, 1'b0, 64'h0, 1'b1);

    // 0xA5 with shift_en toggling 1,0.
    cycle(1'b1, 1'b1, 64'hA5, 1'b0);
    for (int k = 0; k < 22; k++) cycle(1'b1, 1'b0, 64'h0, (k % 2) == 0);

    // 0x3C, then 0xFF offered continuously during the transfer.
    cycle(1'b1, 1'b1, 64'h3C, 1'b1);
    repeat (14) cycle(1'b1, 1'b1, 64'hFF, 1'b1);
    repeat (12) cycle(1'b1, 1'b0, 64'h0, 1'b1);

    // Parity cases (plain words in the default build).
    cycle(1'b1, 1'b1, 64'h07, 1'b0);
    repeat (11) cycle(1'b1, 1'b0, 64'h0, 1'b1);
    cycle(1'b1, 1'b1, 64'h03, 1'b0);
    repeat (11) cycle(1'b1, 1'b0, 64'h0, 1'b1);

    // Reset after three bits of 0xA5, then a fresh 0x81.
    cycle(1'b1, 1'b1, 64'hA5, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 64'h0, 1'b1);
    cycle(1'b0, 1'b1, 64'hFF, 1'b1);
    cycle(1'b1, 1'b1, 64'h81, 1'b0);
    repeat (11) cycle(1'b1, 1'b0, 64'h0, 1'b1);

    // Randomised traffic with occasional resets.
    repeat (3000) begin
      cycle($urandom_range(0, 49) != 0,
            $urandom_range(0, 2) == 0,
            {32'($urandom), 32'($urandom)},
            $urandom_range(0, 3) != 0);
    end
    cycle(1'b1, 1'b0, 64'h0, 1'b0);
    cycle(1'b1, 1'b0, 64'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/piso_shift_ctrl.md
# piso_shift_ctrl

Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, a bit counter, a stall input and a completion pulse. It replaces the fixed 8-bit free-running load/shift register as the serialiser in front of serial links and bit-banged peripherals. It accepts one WIDTH-bit word and emits it one bit per enabled cycle, MSB- or LSB-first. An optional even-parity bit can follow the data.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- load_valid  in  1  load_data is offered.
- load_ready  out  1  block accepts a word this cycle.
- load_data  in  WIDTH  parallel word to serialise.
- sin  in  1  fill bit shifted into the vacated end of the register.
- shift_en  in  1  consumer takes the current sout bit this cycle.
- sout  out  1  current serial bit.
- sout_valid  out  1  sout carries a data or parity bit.
- busy  out  1  a word is in flight.
- done  out  1  one-cycle pulse after the final bit is consumed.

## Operation
- The block has three states: IDLE, SHIFT, and PARITY. PARITY exists only when the macro is enabled.
- Reset (rst_n=0 at an edge) forces:
  - state = IDLE, shift register = 0, counter = 0, parity flop = 0, done = 0.
  - Resulting outputs: load_ready=1, busy=0, sout_valid=0, sout=0.
- **IDLE**
  - load_ready=1.
  - If load_valid=1, the word is accepted. Next cycle: sreg=load_data, cnt=WIDTH, state=SHIFT.
- **SHIFT**
  - load_ready=0, busy=1, sout_valid=1.
  - sout = sreg[WIDTH-1] when MSB_FIRST=1, otherwise sreg[0].
  - On shift_en=1:
    - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
    - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
    - cnt decrements by 1.
  - On shift_en=0, all state holds and sout stays stable.
  - When cnt==1 and shift_en=1, the last data bit is consumed. Next state is PARITY if the macro is enabled, otherwise IDLE with done=1.
- **PARITY**
  - busy=1, sout_valid=1, sout = stored parity bit.
  - On shift_en=1: next state IDLE, done=1.
- **Outside SHIFT/PARITY:** sout=0 and sout_valid=0.
- load_valid while busy is ignored; no word is accepted or queued.
- shift_en in IDLE is ignored.
- sin is sampled only on enabled shifts.
- The counter is $clog2(WIDTH+1) bits wide. It never wraps: it is only decremented in SHIFT, where cnt≥1.

## Timing
- Load acceptance to first sout_valid: 1 cycle.
- Serial bits: one per cycle in which shift_en=1. Minimum word time is WIDTH cycles, plus 1 with parity.
- done asserts in the cycle after the last consumption. It coincides with load_ready=1 returning, and lasts exactly 1 cycle.
- Back-to-back words: minimum gap is 1 cycle. The IDLE/accept cycle has sout_valid=0.
- Reset mid-word aborts immediately:
  - The next cycle is IDLE.
  - No done pulse is generated.
  - The partial word is discarded.
- Simultaneous events:
  - load_valid and shift_en together in IDLE: the load wins and shift_en is ignored.
  - rst_n=0 overrides every other input.

## Configuration
- Macro: PISO_SHIFT_CTRL_PARITY_EN.
- Defined:
  - On load, the parity flop captures ^load_data, so total ones including the parity bit is even.
  - After the last data bit, the block enters PARITY and emits that bit as one extra sout_valid bit.
  - done follows consumption of the parity bit.
- Undefined:
  - No parity flop and no PARITY state.
  - SHIFT goes directly to IDLE.

## Structure
- Package piso_pkg holds:
  - the state typedef (IDLE, SHIFT, PARITY encoded as 2 bits);
  - the WIDTH legality bounds (2 and 64).
- Sub-module piso_bit_cnt: loadable down-counter.
  - Inputs: clk, rst_n, load, load_val, dec.
  - Outputs: cnt, last (cnt==1).
  - Instantiated once.
- The top level contains the FSM, the shift register and the parity flop.

## Test plan
- Reset, then idle: load_ready=1, busy=0, sout_valid=0, sout=0, done=0 on every cycle.
- WIDTH=8, MSB_FIRST=1, load 0xA5, shift_en held 1 → sout 1,0,1,0,0,1,0,1 on 8 consecutive cycles; done pulses once on cycle 10 counted from the load cycle.
- WIDTH=8, MSB_FIRST=0, load 0xA5, shift_en toggling 1,0 → sout 1,0,1,0,0,1,0,1 with each bit held across the stalled cycle; done pulses after 16 cycles of SHIFT.
- Load 0x3C and drive load_valid=1 with 0xFF throughout the transfer → only 0x3C is emitted; 0xFF is not accepted until load_ready=1.
- With PISO_SHIFT_CTRL_PARITY_EN, load 0x07 → nine sout_valid bits, the ninth =1; load 0x03 → ninth bit =0.
- rst_n=0 after 3 bits of 0xA5 → next cycle IDLE, sout_valid=0, no done; a fresh load of 0x81 then serialises correctly.
